// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and decoder FSM state encoding
// for the digit-entry path (ps2_scan_decode, ps2_digit_buffer).
package ps2_pkg;

    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BKSP = 8'h66;
    localparam logic [7:0] SC_ESC  = 8'h76;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

endpackage

// File: rtl/ps2_scan_decode.sv
// Combinational scan-code classifier: byte -> digit/value, backspace, escape.
// Ports: code_i (scan byte); is_digit_o, value_o, is_bksp_o, is_esc_o.
// Macro PS2_KEYPAD_EN: also accept numeric-keypad make codes as digits.
module ps2_scan_decode
    import ps2_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       is_digit_o,
    output logic [3:0] value_o,
    output logic       is_bksp_o,
    output logic       is_esc_o
);

    always_comb begin
        is_digit_o = 1'b0;
        value_o    = 4'd0;
        is_bksp_o  = 1'b0;
        is_esc_o   = 1'b0;
        case (code_i)
            SC_D0:   begin is_digit_o = 1'b1; value_o = 4'd0; end
            SC_D1:   begin is_digit_o = 1'b1; value_o = 4'd1; end
            SC_D2:   begin is_digit_o = 1'b1; value_o = 4'd2; end
            SC_D3:   begin is_digit_o = 1'b1; value_o = 4'd3; end
            SC_D4:   begin is_digit_o = 1'b1; value_o = 4'd4; end
            SC_D5:   begin is_digit_o = 1'b1; value_o = 4'd5; end
            SC_D6:   begin is_digit_o = 1'b1; value_o = 4'd6; end
            SC_D7:   begin is_digit_o = 1'b1; value_o = 4'd7; end
            SC_D8:   begin is_digit_o = 1'b1; value_o = 4'd8; end
            SC_D9:   begin is_digit_o = 1'b1; value_o = 4'd9; end
`ifdef PS2_KEYPAD_EN
            SC_KP0:  begin is_digit_o = 1'b1; value_o = 4'd0; end
            SC_KP1:  begin is_digit_o = 1'b1; value_o = 4'd1; end
            SC_KP2:  begin is_digit_o = 1'b1; value_o = 4'd2; end
            SC_KP3:  begin is_digit_o = 1'b1; value_o = 4'd3; end
            SC_KP4:  begin is_digit_o = 1'b1; value_o = 4'd4; end
            SC_KP5:  begin is_digit_o = 1'b1; value_o = 4'd5; end
            SC_KP6:  begin is_digit_o = 1'b1; value_o = 4'd6; end
            SC_KP7:  begin is_digit_o = 1'b1; value_o = 4'd7; end
            SC_KP8:  begin is_digit_o = 1'b1; value_o = 4'd8; end
            SC_KP9:  begin is_digit_o = 1'b1; value_o = 4'd9; end
`endif
            SC_BKSP: is_bksp_o = 1'b1;
            SC_ESC:  is_esc_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ps2_digit_buffer.sv
// N-digit BCD entry buffer fed by PS/2 scan bytes (make/break/extended aware).
// Ports: clk, rst (sync, active-high), rx_valid, rx_data[7:0], clr;
//        digits[4N-1:0] ([3:0] newest), digit_count, key_strobe, overflow.
// Macro PS2_KEYPAD_EN (in ps2_scan_decode): keypad digits accepted too.
module ps2_digit_buffer
    import ps2_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [3:0]  BLANK_CODE = 4'hF,
    localparam int         CW         = $clog2(NUM_DIGITS + 1),
    localparam int         W          = 4 * NUM_DIGITS
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          clr,
    output logic [W-1:0]  digits,
    output logic [CW-1:0] digit_count,
    output logic          key_strobe,
    output logic          overflow
);

    localparam logic [W-1:0]  BLANK_ALL = {NUM_DIGITS{BLANK_CODE}};
    localparam logic [CW-1:0] FULL      = CW'(NUM_DIGITS);

    state_e        state_q;
    logic [W-1:0]  digits_q;
    logic [CW-1:0] count_q;
    logic          strobe_q;
    logic          ovf_q;

    logic          is_digit;
    logic [3:0]    value;
    logic          is_bksp;
    logic          is_esc;
    logic [W-1:0]  shl_d;
    logic [W-1:0]  shr_d;

    ps2_scan_decode u_decode (
        .code_i     (rx_data),
        .is_digit_o (is_digit),
        .value_o    (value),
        .is_bksp_o  (is_bksp),
        .is_esc_o   (is_esc)
    );

    // Shift by whole nibbles; with one digit the left shift is a replace.
    always_comb begin
        shl_d            = digits_q << 4;
        shl_d[3:0]       = value;
        shr_d            = digits_q >> 4;
        shr_d[W-1 -: 4]  = BLANK_CODE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            digits_q <= BLANK_ALL;
            count_q  <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clr) begin
                state_q  <= ST_IDLE;
                digits_q <= BLANK_ALL;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SC_EXT) begin
                            state_q <= ST_EXT;
                        end else if (rx_data == SC_BRK) begin
                            state_q <= ST_BRK;
                        end else if (is_digit) begin
                            digits_q <= shl_d;
                            strobe_q <= 1'b1;
                            if (count_q == FULL) ovf_q <= 1'b1;
                            else count_q <= count_q + CW'(1);
                        end else if (is_bksp && count_q != '0) begin
                            digits_q <= shr_d;
                            count_q  <= count_q - CW'(1);
                            strobe_q <= 1'b1;
                        end else if (is_esc) begin
                            // Empty, non-overflowed buffer does not change.
                            strobe_q <= (count_q != '0) || ovf_q;
                            digits_q <= BLANK_ALL;
                            count_q  <= '0;
                            ovf_q    <= 1'b0;
                        end
                    end
                    ST_EXT: begin
                        if (rx_data == SC_BRK) state_q <= ST_EXT_BRK;
                        else if (rx_data != SC_EXT) state_q <= ST_IDLE;
                    end
                    ST_BRK:     state_q <= ST_IDLE;
                    ST_EXT_BRK: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign digits      = digits_q;
    assign digit_count = count_q;
    assign key_strobe  = strobe_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_digit_buffer.sv
// Self-checking bench for ps2_digit_buffer (4-digit and 1-digit builds).
// Table vectors, hand sequences and randomized bytes against a queue model.
module tb_ps2_digit_buffer;

    logic        clk = 1'b0;
    logic        rst, clr, rx_valid;
    logic [7:0]  rx_data;

    logic [15:0] digits4;
    logic [2:0]  cnt4;
    logic        stb4, ovf4;
    logic [3:0]  digits1;
    logic [0:0]  cnt1;
    logic        stb1, ovf1;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    ps2_digit_buffer #(.NUM_DIGITS(4), .BLANK_CODE(4'hF)) u_dut4 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .clr(clr), .digits(digits4), .digit_count(cnt4),
        .key_strobe(stb4), .overflow(ovf4)
    );

    ps2_digit_buffer #(.NUM_DIGITS(1), .BLANK_CODE(4'hF)) u_dut1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .clr(clr), .digits(digits1), .digit_count(cnt1),
        .key_strobe(stb1), .overflow(ovf1)
    );

    typedef struct {
        logic        r, c, v;
        logic [7:0]  d;
        logic [15:0] dig;
        logic [3:0]  cnt;
        logic        stb, ovf;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic r, logic c, logic v, logic [7:0] d,
                                logic [15:0] dig, logic [3:0] cnt,
                                logic stb, logic ovf);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.d = d;
        t.dig = dig; t.cnt = cnt; t.stb = stb; t.ovf = ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [7:0] d);
        rst = r; clr = c; rx_valid = v; rx_data = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: digit lists with newest at index 0, prefix flags.
    logic [7:0] dig_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kp_codes[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                  8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    int  NDIG[2] = '{4, 1};
    int  md[2][8];
    int  mcnt[2];
    bit  movf[2];
    bit  mstb[2];
    bit  mext, mbrk;

    function automatic int digit_of(logic [7:0] d);
        for (int i = 0; i < 10; i++) if (dig_codes[i] == d) return i;
`ifdef PS2_KEYPAD_EN
        for (int i = 0; i < 10; i++) if (kp_codes[i] == d) return i;
`endif
        return -1;
    endfunction

    function automatic logic [31:0] mpack(int k);
        logic [31:0] p = 32'hFFFF_FFFF;
        for (int i = 0; i < NDIG[k]; i++)
            if (i < mcnt[k]) p[4*i +: 4] = md[k][i][3:0];
        return p;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; movf[k] = 0; mstb[k] = 0;
        end
        mext = 0; mbrk = 0;
    endtask

    task automatic model_make(logic [7:0] d);
        int v;
        v = digit_of(d);
        for (int k = 0; k < 2; k++) begin
            if (v >= 0) begin
                if (mcnt[k] == NDIG[k]) movf[k] = 1;
                for (int i = NDIG[k] - 1; i > 0; i--) md[k][i] = md[k][i-1];
                md[k][0] = v;
                if (mcnt[k] < NDIG[k]) mcnt[k]++;
                mstb[k] = 1;
            end else if (d == 8'h66 && mcnt[k] > 0) begin
                for (int i = 0; i < NDIG[k] - 1; i++) md[k][i] = md[k][i+1];
                mcnt[k]--;
                mstb[k] = 1;
            end else if (d == 8'h76) begin
                mstb[k] = (mcnt[k] > 0) || movf[k];
                mcnt[k] = 0;
                movf[k] = 0;
            end
        end
    endtask

    task automatic model_step(logic r, logic c, logic v, logic [7:0] d);
        mstb[0] = 0; mstb[1] = 0;
        if (r || c) model_clear();
        else if (v) begin
            if (mbrk) begin
                mbrk = 0; mext = 0;
            end else if (mext) begin
                if (d == 8'hF0) mbrk = 1;
                else if (d != 8'hE0) mext = 0;
            end else if (d == 8'hE0) mext = 1;
            else if (d == 8'hF0) mbrk = 1;
            else model_make(d);
        end
    endtask

    task automatic rand_cycle();
        logic r, c, v;
        logic [7:0] d;
        int sel;
        logic [31:0] p;
        r = ($urandom_range(0, 199) == 0);
        c = ($urandom_range(0, 39) == 0);
        v = ($urandom_range(0, 9) < 7);
        sel = $urandom_range(0, 9);
        if (sel < 5)       d = dig_codes[$urandom_range(0, 9)];
        else if (sel == 5) d = 8'hF0;
        else if (sel == 6) d = 8'hE0;
        else if (sel == 7) d = 8'h66;
        else if (sel == 8) d = ($urandom_range(0, 3) == 0) ? 8'h76
                                : kp_codes[$urandom_range(0, 9)];
        else               d = 8'($urandom_range(0, 255));
        step(r, c, v, d);
        model_step(r, c, v, d);
        p = mpack(0);
        check("rnd4_digits", {16'd0, digits4}, {16'd0, p[15:0]});
        check("rnd4_count", {29'd0, cnt4}, 32'(mcnt[0]));
        check("rnd4_strobe", {31'd0, stb4}, {31'd0, mstb[0]});
        check("rnd4_ovf", {31'd0, ovf4}, {31'd0, movf[0]});
        p = mpack(1);
        check("rnd1_digits", {28'd0, digits1}, {28'd0, p[3:0]});
        check("rnd1_count", {31'd0, cnt1}, 32'(mcnt[1]));
        check("rnd1_strobe", {31'd0, stb1}, {31'd0, mstb[1]});
        check("rnd1_ovf", {31'd0, ovf1}, {31'd0, movf[1]});
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset and ordinary entry
        tab.push_back(mk(1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h1E, 16'hFF12, 2, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h26, 16'hF123, 3, 1, 0));
        tab.push_back(mk(0, 0, 0, 8'h00, 16'hF123, 3, 0, 0));
        // Break pair ignored
        tab.push_back(mk(1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'hF0, 16'hFFF1, 1, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 0, 0));
        // Extended make and extended break discarded
        tab.push_back(mk(1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'hE0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h45, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'hE0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'hF0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h45, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h45, 16'hFFF0, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h76, 16'hFFFF, 0, 1, 0));
        // Overflow then escape
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h1E, 16'hFF12, 2, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h26, 16'hF123, 3, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h25, 16'h1234, 4, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h2E, 16'h2345, 4, 1, 1));
        tab.push_back(mk(0, 0, 1, 8'h76, 16'hFFFF, 0, 1, 0));
        // Backspace, including at empty
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h1E, 16'hFF12, 2, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h66, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h66, 16'hFFFF, 0, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h66, 16'hFFFF, 0, 0, 0));
        // clr priority and FSM reset by clr
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 1, 1, 8'h16, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'hE0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 1, 0, 8'h00, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h16, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(1, 1, 1, 8'h1E, 16'hFFFF, 0, 0, 0));
        // Keypad digit and keypad Enter
`ifdef PS2_KEYPAD_EN
        tab.push_back(mk(0, 0, 1, 8'h69, 16'hFFF1, 1, 1, 0));
        tab.push_back(mk(0, 0, 1, 8'h76, 16'hFFFF, 0, 1, 0));
`else
        tab.push_back(mk(0, 0, 1, 8'h69, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h76, 16'hFFFF, 0, 0, 0));
`endif
        tab.push_back(mk(0, 0, 1, 8'hE0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h5A, 16'hFFFF, 0, 0, 0));
        // Reset mid-sequence: next byte is fresh
        tab.push_back(mk(0, 0, 1, 8'hE0, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(1, 0, 0, 8'h00, 16'hFFFF, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 8'h45, 16'hFFF0, 1, 1, 0));

        foreach (tab[i]) begin
            step(tab[i].r, tab[i].c, tab[i].v, tab[i].d);
            nchecks++;
            if (digits4 !== tab[i].dig || {1'b0, cnt4} !== tab[i].cnt ||
                stb4 !== tab[i].stb || ovf4 !== tab[i].ovf) begin
                nerr++;
                $display("FAIL vec%0d: got dig=%h cnt=%0d stb=%b ovf=%b expected dig=%h cnt=%0d stb=%b ovf=%b",
                         i, digits4, cnt4, stb4, ovf4,
                         tab[i].dig, tab[i].cnt, tab[i].stb, tab[i].ovf);
            end
        end

        // Typematic repeats: each repeated make enters a digit with a pulse
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 8'h16);
            check("typematic_strobe", {31'd0, stb4}, 32'd1);
        end
        check("typematic_digits", {16'd0, digits4}, 32'h1111);
        check("typematic_ovf", {31'd0, ovf4}, 32'd1);
        step(0, 0, 0, 8'h00);
        check("strobe_one_cycle", {31'd0, stb4}, 32'd0);
        check("ovf_sticky", {31'd0, ovf4}, 32'd1);

        // Single-digit build: replacement and overflow on second digit
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h16);
        check("n1_first_digit", {28'd0, digits1}, 32'h1);
        check("n1_first_ovf", {31'd0, ovf1}, 32'd0);
        step(0, 0, 1, 8'h1E);
        check("n1_second_digit", {28'd0, digits1}, 32'h2);
        check("n1_second_cnt", {31'd0, cnt1}, 32'd1);
        check("n1_second_ovf", {31'd0, ovf1}, 32'd1);
        step(0, 0, 1, 8'h66);
        check("n1_bksp_digit", {28'd0, digits1}, 32'hF);
        check("n1_bksp_cnt", {31'd0, cnt1}, 32'd0);

        // Randomized bytes against the model, from a known reset
        step(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 8'h00);
        for (int i = 0; i < 1500; i++) rand_cycle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
